// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch front end.
package fetch_pkg;

    localparam int N_DEFAULT    = 64;
    localparam int ILEN_DEFAULT = 32;
    localparam int PC_STEP      = 4;

    typedef struct packed {
        logic [N_DEFAULT-1:0]    pc;
        logic [ILEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_TRAP,
        RD_TRAPRET,
        RD_BRANCH
    } redirect_cause_e;

    // Trap entry outranks trap return, which outranks a branch.
    function automatic redirect_cause_e redirect_cause(input logic trap,
                                                       input logic trap_ret,
                                                       input logic branch);
        redirect_cause_e cause;
        cause = RD_NONE;
        if (branch)   cause = RD_BRANCH;
        if (trap_ret) cause = RD_TRAPRET;
        if (trap)     cause = RD_TRAP;
        return cause;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with a single-cycle flush; read data reads as zero while empty.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !flush && (count != CW'(DEPTH));
    assign do_pop   = pop && !flush && (count != '0);
    assign pop_data = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (!reset) count <= CW'(DEPTH));

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch front end: sequential PCs, prioritised redirects, in-flight drop tracking.
// Define FETCH_MISALIGN_TRAP_EN to flag misaligned redirect targets and block fetch while flagged.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int            N        = N_DEFAULT,
    parameter int            ILEN     = ILEN_DEFAULT,
    parameter int            DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_enable,
    input  logic            interruptSignal,
    input  logic [N-1:0]    PC_TrapTrigger,
    input  logic            trapReturn,
    input  logic [N-1:0]    PC_TrapReturn,
    input  logic            PCSrc_F,
    input  logic [N-1:0]    PCBranch_F,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [N-1:0]    req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [N-1:0]    inst_pc,
    output logic            misalign_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    redirect_cause_e   cause;
    logic              redirect;
    logic [N-1:0]      target;
    logic [N-1:0]      fetch_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     pc_count;
    logic [CW:0]       occupied;
    logic              fire;
    logic              rsp_accept;
    logic              rsp_keep;
    logic              pop;
    logic              fault_block;
    logic [N-1:0]      rsp_pc;
    logic [N+ILEN-1:0] q_head;

    assign cause    = redirect_cause(interruptSignal, trapReturn, PCSrc_F);
    assign redirect = (cause != RD_NONE);

    always_comb begin
        target = fetch_pc;
        case (cause)
            RD_TRAP:    target = PC_TrapTrigger;
            RD_TRAPRET: target = PC_TrapReturn;
            RD_BRANCH:  target = PCBranch_F;
            default:    target = fetch_pc;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= |target[1:0];
        end
    end

    assign misalign_fault = fault_q;
    assign fault_block    = fault_q;
`else
    assign misalign_fault = 1'b0;
    assign fault_block    = 1'b0;
`endif

    // Queued words plus outstanding requests bound the issue window so a response always has a slot.
    assign occupied  = {1'b0, q_count} + {1'b0, inflight};
    assign req_valid = reset && fetch_enable && !redirect && !fault_block &&
                       (drop_cnt == '0) && (occupied < (CW+1)'(DEPTH));
    assign req_addr  = fetch_pc;
    assign fire      = req_valid && req_ready;

    assign rsp_accept = rsp_valid && (inflight != '0);
    assign rsp_keep   = rsp_accept && (drop_cnt == '0) && !redirect && (pc_count != '0);

    assign inst_valid = (q_count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_pc    = q_head[N+ILEN-1:ILEN];
    assign inst_data  = q_head[ILEN-1:0];

    // A response arriving in the redirect cycle belongs to the old stream, so it is not counted as pending drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(rsp_accept);
            if (redirect) begin
                fetch_pc <= target;
                drop_cnt <= inflight - CW'(rsp_accept);
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + N'(PC_STEP);
                end
                if ((drop_cnt != '0) && rsp_accept) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .pop_data  (rsp_pc),
        .count     (pc_count)
    );

    fetch_fifo #(
        .WIDTH (N + ILEN),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (rsp_keep),
        .push_data ({rsp_pc, rsp_data}),
        .pop       (pop),
        .pop_data  (q_head),
        .count     (q_count)
    );

    assert property (@(posedge clk) disable iff (!reset) occupied <= (CW+1)'(DEPTH));
    assert property (@(posedge clk) disable iff (!reset) inflight <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!reset) !(fire && redirect));

endmodule
